// File: rtl/msg_rx_link.sv
// Word-to-packet receive link: assembles WORDS_PER_PACKET words into a packet, aborts stale
// partial packets after an idle timeout, and buffers completed packets in a fall-through FIFO.
module msg_rx_link #(
  parameter int unsigned WORD_SIZE        = 8,
  parameter int unsigned WORDS_PER_PACKET = 4,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned TIMEOUT_CLKS     = 1024,
  localparam int unsigned PKT_W           = WORD_SIZE * WORDS_PER_PACKET,
  localparam int unsigned LVL_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 data_in_valid,
  input  logic                 rd_en,
  output logic [PKT_W-1:0]     data_out,
  output logic                 empty,
  output logic                 full,
  output logic [LVL_W-1:0]     level,
  output logic [7:0]           drop_count,
  output logic [7:0]           timeout_count,
  output logic                 timeout_pulse
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_PACKET);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS);
  localparam int unsigned STW   = PKT_W - WORD_SIZE;

  logic [CNT_W-1:0] r_word_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [STW-1:0]   r_words;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [7:0]       r_drop_cnt;
  logic [7:0]       r_to_total;
  logic             r_pulse;
  logic [PKT_W-1:0] r_mem [FIFO_DEPTH];

  logic             w_last;
  logic             w_abort;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_drop;
  logic [PKT_W-1:0] w_pkt;

  always_comb begin
    w_pkt   = {r_words, data_in};
    w_last  = (r_word_cnt == CNT_W'(WORDS_PER_PACKET - 1));
    w_abort = !data_in_valid && (r_word_cnt != '0) && (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));
    w_push  = data_in_valid && w_last;
    w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    w_pop   = rd_en && (r_level != '0);
    // A pop frees the slot on the same edge, so a push into a full FIFO still lands.
    w_wr    = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_word_cnt <= '0;
      r_to_cnt   <= '0;
      r_words    <= '0;
      r_pulse    <= 1'b0;
      r_to_total <= '0;
    end else begin
      r_pulse <= w_abort;
      if (data_in_valid) begin
        r_words    <= w_pkt[STW-1:0];
        r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
        r_to_cnt   <= '0;
      end else if (w_abort) begin
        r_word_cnt <= '0;
        r_to_cnt   <= '0;
        if (r_to_total != 8'hFF) r_to_total <= r_to_total + 8'd1;
      end else if (r_word_cnt != '0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_wr && !w_pop) r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_wr) r_level <= r_level - LVL_W'(1);
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_pkt;
  end

  always_comb begin
    data_out      = r_mem[r_rptr];
    empty         = (r_level == '0);
    full          = w_full;
    level         = r_level;
    drop_count    = r_drop_cnt;
    timeout_count = r_to_total;
    timeout_pulse = r_pulse;
  end

endmodule

// File: tb/tb_msg_rx_link.sv
// Randomized and directed bench for msg_rx_link with a word-list / packet-queue reference model.
module tb_msg_rx_link;

  localparam int unsigned WS = 8;
  localparam int unsigned WPP = 4;
  localparam int unsigned FD = 4;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_out;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic [7:0]  drop_count;
  logic [7:0]  timeout_count;
  logic        timeout_pulse;

  msg_rx_link #(
    .WORD_SIZE(WS),
    .WORDS_PER_PACKET(WPP),
    .FIFO_DEPTH(FD),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .rd_en(rd_en),
    .data_out(data_out),
    .empty(empty),
    .full(full),
    .level(level),
    .drop_count(drop_count),
    .timeout_count(timeout_count),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: pending words of the current packet, idle cycles since the last
  // word, and the scoreboard of packets the FIFO should hold, oldest first.
  logic [7:0]  words[$];
  logic [31:0] sb_q[$];
  int          idle_cnt = 0;
  int          exp_drops = 0;
  int          exp_touts = 0;
  bit          exp_pulse = 0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    words.delete();
    sb_q.delete();
    idle_cnt = 0;
    exp_drops = 0;
    exp_touts = 0;
    exp_pulse = 0;
  endfunction

  function automatic void model_step(bit v, logic [7:0] d, bit r);
    bit          was_full = (sb_q.size() == FD);
    bit          pop = r && (sb_q.size() > 0);
    logic [31:0] pkt;
    exp_pulse = 0;
    if (pop) void'(sb_q.pop_front());
    if (v) begin
      words.push_back(d);
      idle_cnt = 0;
      if (words.size() == WPP) begin
        pkt = '0;
        foreach (words[i]) pkt = (pkt << WS) | 32'(words[i]);
        words.delete();
        if (!was_full || pop) sb_q.push_back(pkt);
        else if (exp_drops < 255) exp_drops++;
      end
    end else if (words.size() != 0) begin
      if (idle_cnt == TO - 1) begin
        words.delete();
        idle_cnt = 0;
        exp_pulse = 1;
        if (exp_touts < 255) exp_touts++;
      end else begin
        idle_cnt++;
      end
    end
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d, input bit r);
    @(negedge clk);
    data_in_valid = v;
    data_in = d;
    rd_en = r;
    @(posedge clk);
    model_step(v, d, r);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_pkt(input logic [31:0] p, input bit rd_last);
    for (int i = 0; i < WPP; i++) cyc(1'b1, p[31-8*i -: 8], (i == WPP - 1) && rd_last);
  endtask

  task automatic pop_n(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    data_in_valid = 1'b0;
    rd_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    model_step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: outputs only change on rising edges, so the falling edge is a stable sample point.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("empty", 32'(empty), 32'(sb_q.size() == 0));
      chk("full", 32'(full), 32'(sb_q.size() == FD));
      chk("level", 32'(level), 32'(sb_q.size()));
      chk("drop_count", 32'(drop_count), 32'(exp_drops));
      chk("timeout_count", 32'(timeout_count), 32'(exp_touts));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(exp_pulse));
      if (!empty && sb_q.size() > 0) chk("data_out", data_out, sb_q[0]);
    end
  end

  initial begin
    int mode;
    model_reset();
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    model_step(1'b0, 8'h00, 1'b0);

    send_pkt(32'h11223344, 1'b0);
    idle(2);
    pop_n(1);
    idle(2);

    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    idle(TO + 3);
    send_pkt(32'h01020304, 1'b0);
    pop_n(1);

    cyc(1'b1, 8'hAA, 1'b0);
    idle(14);
    cyc(1'b1, 8'hBB, 1'b0);
    idle(15);
    cyc(1'b1, 8'hCC, 1'b0);
    cyc(1'b1, 8'hDD, 1'b0);
    pop_n(1);

    // Push into an empty FIFO with rd_en on the same edge: the pop must be ignored.
    send_pkt(32'hC0FFEE01, 1'b1);
    pop_n(2);

    for (int i = 0; i < 6; i++) send_pkt(32'hA0A0A000 + 32'(i), 1'b0);
    pop_n(5);

    for (int i = 0; i < 4; i++) send_pkt(32'hB0000000 + 32'(i), 1'b0);
    send_pkt(32'hB00000FF, 1'b1);
    pop_n(5);

    for (int i = 0; i < 3; i++) send_pkt(32'hD0000000 + 32'(i), 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b1, 8'h88, 1'b0);
    do_reset();
    send_pkt(32'h5A6B7C8D, 1'b0);
    pop_n(2);

    for (int seg = 0; seg < 80; seg++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 2) begin
        repeat ($urandom_range(1, 3)) cyc(1'b1, 8'($urandom), $urandom_range(0, 3) == 0);
        repeat ($urandom_range(13, 18)) cyc(1'b0, 8'($urandom), $urandom_range(0, 3) == 0);
      end else begin
        repeat (40) cyc($urandom_range(0, 9) < (mode == 0 ? 7 : 9), 8'($urandom),
                        $urandom_range(0, 19) < (mode == 0 ? 6 : 1));
      end
      if (seg == 40) do_reset();
    end
    pop_n(6);

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msg_rx_link.md
MSG_RX_LINK -- requirements
Module: msg_rx_link

Interface
REQ-001 Parameter WORD_SIZE, default 8: width of each received word.
REQ-002 Parameter WORDS_PER_PACKET, default 4: number of words per packet, minimum 2.
REQ-003 Parameter FIFO_DEPTH, default 8: number of packets buffered; power of two, minimum 2.
REQ-004 Parameter TIMEOUT_CLKS, default 1024: length of the idle gap, in clocks, that aborts a partial packet; minimum 2.
REQ-005 Derived constant PKT_W = WORD_SIZE*WORDS_PER_PACKET.
REQ-006 Port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-007 Port n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port data_in, input, WORD_SIZE bits: received word.
REQ-009 Port data_in_valid, input, 1 bit: single-cycle strobe qualifying data_in.
REQ-010 Port rd_en, input, 1 bit: pops the head packet.
REQ-011 Port data_out, output, PKT_W bits: head packet (first-word fall-through).
REQ-012 Port empty, output, 1 bit: FIFO holds no packets.
REQ-013 Port full, output, 1 bit: FIFO holds FIFO_DEPTH packets.
REQ-014 Port level, output, clog2(FIFO_DEPTH)+1 bits: number of packets stored.
REQ-015 Port drop_count, output, 8 bits: count of completed packets lost to overflow; saturates at 255.
REQ-016 Port timeout_count, output, 8 bits: count of partial packets aborted by timeout; saturates at 255.
REQ-017 Port timeout_pulse, output, 1 bit: one-cycle pulse for each abort.

Function
REQ-018 Assembly: each word with data_in_valid=1 is captured on that edge; the first word of a packet occupies data_out[PKT_W-1 -: WORD_SIZE]; later words fill successively lower slices.
REQ-019 Word counter: runs 0..WORDS_PER_PACKET-1 and wraps to 0 on the edge that captures the last word.
REQ-020 Completion: the edge that captures the last word also writes the whole packet (stored words plus the current data_in) into the FIFO; empty falls, with data_out valid, after that edge (latency 1 clock from the strobe).
REQ-021 Timeout counter: cleared on every accepted word; increments on each cycle with word counter ≠ 0 and data_in_valid=0; holds at 0 while word counter = 0.
REQ-022 Timeout abort: in a cycle where the timeout counter = TIMEOUT_CLKS-1 and data_in_valid=0, the next edge clears the word counter and the timeout counter, raises timeout_pulse for exactly one cycle and increments timeout_count.
REQ-023 Valid wins: if data_in_valid=1 in the cycle the timeout would fire, the word is accepted and no abort occurs.
REQ-024 An aborted partial packet is never written to the FIFO.
REQ-025 FIFO pointers: read and write pointers wrap modulo FIFO_DEPTH.
REQ-026 Status outputs: full = (level == FIFO_DEPTH); empty = (level == 0).
REQ-027 Read when empty: rd_en is ignored and no state changes.
REQ-028 Push when full with no pop: the completed packet is discarded, drop_count increments (saturating) and the FIFO contents are unchanged.
REQ-029 Push when full with a simultaneous pop: both occur, the packet is stored and level stays at FIFO_DEPTH.
REQ-030 Simultaneous push and pop at any other level: level is unchanged.
REQ-031 Pop on the empty-to-non-empty edge: a push into an empty FIFO is not readable in the same cycle; rd_en in that cycle is ignored.
REQ-032 data_out holds the head entry whenever empty=0; its value is don't-care when empty=1.

Reset
REQ-033 While n_reset=0, asynchronously: word counter, timeout counter, both FIFO pointers, level, drop_count and timeout_count are 0; empty=1; full=0; timeout_pulse=0.
REQ-034 Reset asserted mid-packet discards the partial packet and all FIFO contents; no pulse is generated.
REQ-035 FIFO storage RAM is not reset.
REQ-036 Release of reset takes effect on the first rising edge with n_reset=1.

Verification (WORD_SIZE=8, WORDS_PER_PACKET=4, FIFO_DEPTH=4, TIMEOUT_CLKS=16)
REQ-037 Words 0x11,0x22,0x33,0x44 strobed -> one edge after the 0x44 strobe: empty=0, data_out=0x11223344, level=1; rd_en=1 for one cycle -> empty=1.
REQ-038 Words 0xAA,0xBB, then 16 idle cycles -> timeout_pulse high for 1 cycle, timeout_count=1; then 0x01,0x02,0x03,0x04 -> data_out=0x01020304.
REQ-039 Word 0xAA, then a strobe of 0xBB exactly on idle cycle 15 -> no abort, timeout_count=0; two more words complete the packet 0xAABB....
REQ-040 Six packets P0..P5 with no reads -> full=1 after P3, drop_count=2, pops return P0..P3 in order.
REQ-041 FIFO full, rd_en asserted in the same cycle as a completing word -> level stays 4, no drop, next pops return P1,P2,P3,new.
REQ-042 n_reset pulsed low after 2 words with 3 packets stored -> empty=1, level=0, counters 0; the next 4 words form a correctly aligned packet.
